trace_checker: RTL

TRACE_CHECKER -- requirements
Module: trace_checker

---
 rtl/trace_checker_if.sv | 26 ++
 rtl/trace_checker.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/trace_checker_if.sv
// Commit-trace and golden-entry bundle between a CPU debug port, a golden
// reference source and the trace checker.
interface trace_checker_if;
    logic [31:0] debug_wb_pc;
    logic [3:0]  debug_wb_rf_we;
    logic [4:0]  debug_wb_rf_wnum;
    logic [31:0] debug_wb_rf_wdata;
    logic        gold_valid;
    logic        gold_ready;
    logic [31:0] gold_pc;
    logic [4:0]  gold_wnum;
    logic [31:0] gold_wdata;
    logic        gold_last;

    modport master (
        output debug_wb_pc, debug_wb_rf_we, debug_wb_rf_wnum, debug_wb_rf_wdata,
        output gold_valid, gold_pc, gold_wnum, gold_wdata, gold_last,
        input  gold_ready
    );

    modport slave (
        input  debug_wb_pc, debug_wb_rf_we, debug_wb_rf_wnum, debug_wb_rf_wdata,
        input  gold_valid, gold_pc, gold_wnum, gold_wdata, gold_last,
        output gold_ready
    );
endinterface

// File: rtl/trace_checker.sv
// Captures register-file writebacks into a small FIFO and checks them in order
// against a golden stream, with overflow, mismatch and stall detection.
module trace_checker #(
    parameter int unsigned END_CNT_W   = 16,
    parameter int unsigned STALL_LIMIT = 1024,
    parameter int unsigned FIFO_DEPTH  = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 stop_on_err,
    trace_checker_if.slave       tr,
    output logic [1:0]           state,
    output logic [1:0]           fail_code,
    output logic [END_CNT_W-1:0] err_cnt,
    output logic [31:0]          commit_cnt,
    output logic [31:0]          err_pc,
    output logic [4:0]           err_wnum,
    output logic [31:0]          err_got,
    output logic [31:0]          err_exp
);

    localparam int unsigned PtrW   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CntW   = PtrW + 1;
    localparam int unsigned StallW = $clog2(STALL_LIMIT + 1);
    localparam logic [CntW-1:0]   FullCnt  = CntW'(FIFO_DEPTH);
    localparam logic [StallW-1:0] StallMax = StallW'(STALL_LIMIT - 1);

    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StRun  = 2'b01,
        StPass = 2'b10,
        StFail = 2'b11
    } state_e;

    state_e               state_q, state_d;
    logic [1:0]           fail_code_q, fail_code_d;
    logic [END_CNT_W-1:0] err_cnt_q, err_cnt_d;
    logic [31:0]          commit_cnt_q, commit_cnt_d;
    logic [31:0]          err_pc_q, err_pc_d;
    logic [4:0]           err_wnum_q, err_wnum_d;
    logic [31:0]          err_got_q, err_got_d;
    logic [31:0]          err_exp_q, err_exp_d;
    logic [StallW-1:0]    stall_q, stall_d;
    logic [PtrW-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]      count_q, count_d;

    logic [31:0] fifo_pc    [FIFO_DEPTH];
    logic [4:0]  fifo_wnum  [FIFO_DEPTH];
    logic [3:0]  fifo_we    [FIFO_DEPTH];
    logic [31:0] fifo_wdata [FIFO_DEPTH];

    logic        run, commit, full, ready, pop, push, overflow;
    logic        match, mismatch, timeout;
    logic [31:0] byte_mask, got_masked, exp_masked;

    always_comb begin
        run       = (state_q == StRun);
        commit    = run && (tr.debug_wb_rf_we != 4'b0) && (tr.debug_wb_rf_wnum != 5'd0);
        full      = (count_q == FullCnt);
        ready     = run && (count_q != '0);
        pop       = ready && tr.gold_valid;
        // A pop in the same cycle frees the slot, so a full FIFO can still accept.
        push      = commit && (!full || pop);
        overflow  = commit && full && !pop;
        byte_mask = {{8{fifo_we[rd_ptr_q][3]}}, {8{fifo_we[rd_ptr_q][2]}},
                     {8{fifo_we[rd_ptr_q][1]}}, {8{fifo_we[rd_ptr_q][0]}}};
        got_masked = fifo_wdata[rd_ptr_q] & byte_mask;
        exp_masked = tr.gold_wdata & byte_mask;
        match     = (fifo_pc[rd_ptr_q] == tr.gold_pc) &&
                    (fifo_wnum[rd_ptr_q] == tr.gold_wnum) &&
                    (got_masked == exp_masked);
        mismatch  = pop && !match;
        timeout   = run && !commit && (stall_q == StallMax);
    end

    always_comb begin
        state_d      = state_q;
        fail_code_d  = fail_code_q;
        err_cnt_d    = err_cnt_q;
        commit_cnt_d = commit_cnt_q;
        err_pc_d     = err_pc_q;
        err_wnum_d   = err_wnum_q;
        err_got_d    = err_got_q;
        err_exp_d    = err_exp_q;
        stall_d      = stall_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StRun;
                    stall_d = '0;
                end
            end
            StRun: begin
                stall_d = commit ? '0 : stall_q + StallW'(1);
                if (push) begin
                    wr_ptr_d     = wr_ptr_q + PtrW'(1);
                    commit_cnt_d = commit_cnt_q + 32'd1;
                end
                if (pop) begin
                    rd_ptr_d = rd_ptr_q + PtrW'(1);
                end
                if (push && !pop) begin
                    count_d = count_q + CntW'(1);
                end else if (!push && pop) begin
                    count_d = count_q - CntW'(1);
                end
                if (mismatch) begin
                    err_cnt_d = (&err_cnt_q) ? err_cnt_q : err_cnt_q + END_CNT_W'(1);
                    // Saturation never returns to zero, so zero means no prior mismatch.
                    if (err_cnt_q == '0) begin
                        err_pc_d   = fifo_pc[rd_ptr_q];
                        err_wnum_d = fifo_wnum[rd_ptr_q];
                        err_got_d  = got_masked;
                        err_exp_d  = exp_masked;
                    end
                end
                if (overflow) begin
                    state_d     = StFail;
                    fail_code_d = 2'd2;
                end else if (mismatch && stop_on_err) begin
                    state_d     = StFail;
                    fail_code_d = 2'd1;
                end else if (pop && tr.gold_last) begin
                    if (err_cnt_d == '0) begin
                        state_d = StPass;
                    end else begin
                        state_d     = StFail;
                        fail_code_d = 2'd1;
                    end
                end else if (timeout) begin
                    state_d     = StFail;
                    fail_code_d = 2'd3;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            fail_code_q  <= '0;
            err_cnt_q    <= '0;
            commit_cnt_q <= '0;
            err_pc_q     <= '0;
            err_wnum_q   <= '0;
            err_got_q    <= '0;
            err_exp_q    <= '0;
            stall_q      <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
        end else begin
            state_q      <= state_d;
            fail_code_q  <= fail_code_d;
            err_cnt_q    <= err_cnt_d;
            commit_cnt_q <= commit_cnt_d;
            err_pc_q     <= err_pc_d;
            err_wnum_q   <= err_wnum_d;
            err_got_q    <= err_got_d;
            err_exp_q    <= err_exp_d;
            stall_q      <= stall_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
        end
    end

    // Storage needs no reset: pointers and count define which entries are live.
    always_ff @(posedge clk) begin
        if (!rst && push) begin
            fifo_pc[wr_ptr_q]    <= tr.debug_wb_pc;
            fifo_wnum[wr_ptr_q]  <= tr.debug_wb_rf_wnum;
            fifo_we[wr_ptr_q]    <= tr.debug_wb_rf_we;
            fifo_wdata[wr_ptr_q] <= tr.debug_wb_rf_wdata;
        end
    end

    assign tr.gold_ready = ready && !rst;
    assign state         = state_q;
    assign fail_code     = fail_code_q;
    assign err_cnt       = err_cnt_q;
    assign commit_cnt    = commit_cnt_q;
    assign err_pc        = err_pc_q;
    assign err_wnum      = err_wnum_q;
    assign err_got       = err_got_q;
    assign err_exp       = err_exp_q;

endmodule
